// File: rtl/reg_wb_sched.sv
// Write-back scheduler: round-robin arbitration of three write-back sources onto
// one register-file write port, plus a register scoreboard driving the decode stall.
module reg_wb_sched #(
  parameter int NSRC = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        ISSUE_EN,
  input  logic [4:0]  ISSUE_RD,
  input  logic [4:0]  RS1_ADDR,
  input  logic [4:0]  RS2_ADDR,
  output logic        HAZARD,
  input  logic        S0_VALID,
  input  logic [4:0]  S0_ADDR,
  input  logic [31:0] S0_DATA,
  output logic        S0_READY,
  input  logic        S1_VALID,
  input  logic [4:0]  S1_ADDR,
  input  logic [31:0] S1_DATA,
  output logic        S1_READY,
  input  logic        S2_VALID,
  input  logic [4:0]  S2_ADDR,
  input  logic [31:0] S2_DATA,
  output logic        S2_READY,
  output logic [4:0]  WADDR,
  output logic [31:0] WDATA,
  output logic [31:0] BUSY,
  output logic [5:0]  PEND_CNT
);

  logic [NSRC-1:0] valid_s;
  logic [2:0]      gnt_s;
  logic            xfer_s;
  logic [4:0]      sel_addr_s;
  logic [31:0]     sel_data_s;
  logic [1:0]      ptr_r;
  logic [1:0]      ptr_nxt_s;
  logic [4:0]      waddr_r;
  logic [31:0]     wdata_r;
  logic [31:0]     busy_r;
  logic [31:0]     busy_nxt_s;
  logic [31:0]     clr_mask_s;
  logic [31:0]     set_mask_s;
  logic [5:0]      pend_cnt_r;
  logic            hazard_s;

  function automatic logic [5:0] popcnt32(input logic [31:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  function automatic logic [31:0] onehot32(input logic [4:0] a);
    logic [31:0] m;
    m = 32'd0;
    m[a] = 1'b1;
    return m;
  endfunction

  assign valid_s = {S2_VALID, S1_VALID, S0_VALID};

  // Round-robin grant: priority search starts at the pointer and wraps.
  always_comb begin
    gnt_s = 3'b000;
    case (ptr_r)
      2'd1: begin
        if (valid_s[1])      gnt_s = 3'b010;
        else if (valid_s[2]) gnt_s = 3'b100;
        else if (valid_s[0]) gnt_s = 3'b001;
        else                 gnt_s = 3'b000;
      end
      2'd2: begin
        if (valid_s[2])      gnt_s = 3'b100;
        else if (valid_s[0]) gnt_s = 3'b001;
        else if (valid_s[1]) gnt_s = 3'b010;
        else                 gnt_s = 3'b000;
      end
      default: begin
        if (valid_s[0])      gnt_s = 3'b001;
        else if (valid_s[1]) gnt_s = 3'b010;
        else if (valid_s[2]) gnt_s = 3'b100;
        else                 gnt_s = 3'b000;
      end
    endcase
  end

  assign S0_READY = gnt_s[0];
  assign S1_READY = gnt_s[1];
  assign S2_READY = gnt_s[2];
  assign xfer_s   = |gnt_s;

  // Granted source mux and the pointer value following that grant.
  always_comb begin
    sel_addr_s = 5'd0;
    sel_data_s = 32'd0;
    ptr_nxt_s  = ptr_r;
    case (gnt_s)
      3'b001: begin
        sel_addr_s = S0_ADDR;
        sel_data_s = S0_DATA;
        ptr_nxt_s  = 2'd1;
      end
      3'b010: begin
        sel_addr_s = S1_ADDR;
        sel_data_s = S1_DATA;
        ptr_nxt_s  = 2'd2;
      end
      3'b100: begin
        sel_addr_s = S2_ADDR;
        sel_data_s = S2_DATA;
        ptr_nxt_s  = 2'd0;
      end
      default: begin
        sel_addr_s = 5'd0;
        sel_data_s = 32'd0;
        ptr_nxt_s  = ptr_r;
      end
    endcase
  end

  // Stall decision uses registered BUSY only; a same-cycle write-back does not bypass.
  always_comb begin
    hazard_s = 1'b0;
    if ((RS1_ADDR != 5'd0) && busy_r[RS1_ADDR]) begin
      hazard_s = 1'b1;
    end else if ((RS2_ADDR != 5'd0) && busy_r[RS2_ADDR]) begin
      hazard_s = 1'b1;
    end else if (ISSUE_EN && (ISSUE_RD != 5'd0) && busy_r[ISSUE_RD]) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign HAZARD = hazard_s;

  // Scoreboard next state: set applied after clear so set wins; flush overrides both.
  always_comb begin
    clr_mask_s = 32'd0;
    set_mask_s = 32'd0;
    busy_nxt_s = busy_r;
    if (xfer_s && (sel_addr_s != 5'd0)) begin
      clr_mask_s = onehot32(sel_addr_s);
    end else begin
      clr_mask_s = 32'd0;
    end
    if (ISSUE_EN && !hazard_s && (ISSUE_RD != 5'd0)) begin
      set_mask_s = onehot32(ISSUE_RD);
    end else begin
      set_mask_s = 32'd0;
    end
    if (FLUSH) begin
      busy_nxt_s = 32'd0;
    end else begin
      busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~32'd1;
    end
  end

  // State registers: pointer, write-port pipeline, scoreboard and its count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_r      <= 2'd0;
      waddr_r    <= 5'd0;
      wdata_r    <= 32'd0;
      busy_r     <= 32'd0;
      pend_cnt_r <= 6'd0;
    end else begin
      ptr_r      <= ptr_nxt_s;
      waddr_r    <= xfer_s ? sel_addr_s : 5'd0;
      wdata_r    <= xfer_s ? sel_data_s : 32'd0;
      busy_r     <= busy_nxt_s;
      pend_cnt_r <= popcnt32(busy_nxt_s);
    end
  end

  assign WADDR    = waddr_r;
  assign WDATA    = wdata_r;
  assign BUSY     = busy_r;
  assign PEND_CNT = pend_cnt_r;

endmodule
